// File: rtl/requant_pkg.sv
// Shared widths, saturation-bound helper and lane result type for the requantizer.
package requant_pkg;

  localparam int L_DATAIN_DEF  = 24;
  localparam int L_DATAOUT_DEF = 16;
  localparam int N_CH_DEF      = 4;
  localparam int L_SHIFT_DEF   = 5;
  localparam int L_CNT_DEF     = 16;

  typedef struct packed {
    logic signed [31:0] max;
    logic signed [31:0] min;
  } sat_bounds_t;

  typedef struct packed {
    logic signed [L_DATAOUT_DEF-1:0] val;
    logic                            sat;
  } lane_res_t;

  // Two's-complement range of a w-bit signed value.
  function automatic sat_bounds_t sat_bounds(input int unsigned w);
    sat_bounds_t b;
    b.max = (32'sd1 <<< (w - 1)) - 32'sd1;
    b.min = -(32'sd1 <<< (w - 1));
    return b;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: shift/round feeds the S1 register, clamp reads it back.
// Purely combinational; no handshake of its own.
module requant_lane
  import requant_pkg::*;
#(
  parameter int L_datain  = L_DATAIN_DEF,
  parameter int L_dataout = L_DATAOUT_DEF,
  parameter int L_SHIFT   = L_SHIFT_DEF
) (
  input  logic [L_datain-1:0]  din,
  input  logic [L_SHIFT-1:0]   shift,
  input  logic                 round,
  output logic [L_datain:0]    shifted,
  input  logic [L_datain:0]    sat_in,
  output logic [L_dataout-1:0] res_val,
  output logic                 res_sat
);

  localparam int LW = L_datain + 1;
  localparam logic [L_SHIFT-1:0] SH_MAX = L_SHIFT'(L_datain - 1);
  localparam sat_bounds_t BND = sat_bounds(L_dataout);
  localparam logic signed [LW-1:0] MAX_W = LW'(BND.max);
  localparam logic signed [LW-1:0] MIN_W = LW'(BND.min);

  logic [L_SHIFT-1:0]    sh;
  logic signed [LW-1:0]  ext;
  logic signed [LW-1:0]  rnd;
  logic signed [LW-1:0]  sum;
  logic signed [LW-1:0]  s1;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  always_comb begin
    sh  = (shift > SH_MAX) ? SH_MAX : shift;
    ext = {din[L_datain-1], din};
    rnd = '0;
    if (round && (sh != '0)) begin
      rnd = LW'(1) << (sh - L_SHIFT'(1));
    end
    sum     = ext + rnd;
    shifted = sum >>> sh;
  end

  always_comb begin
    s1      = sat_in;
    res_val = s1[L_dataout-1:0];
    res_sat = 1'b0;
    if (s1 > MAX_W) begin
      res_val = MAX_W[L_dataout-1:0];
      res_sat = 1'b1;
    end else if (s1 < MIN_W) begin
      res_val = MIN_W[L_dataout-1:0];
      res_sat = 1'b1;
    end
  end

endmodule

// File: rtl/saturate_requant_pipe.sv
// N_CH-lane shift/round/saturate pipe: 2-cycle latency, 1 beat/cycle, in_ready follows out_ready combinationally.
// Optional saturation event counter under SAT_STATS_EN.
module saturate_requant_pipe
  import requant_pkg::*;
#(
  parameter int L_datain  = L_DATAIN_DEF,
  parameter int L_dataout = L_DATAOUT_DEF,
  parameter int N_CH      = N_CH_DEF,
  parameter int L_SHIFT   = L_SHIFT_DEF,
  parameter int L_CNT     = L_CNT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*L_datain-1:0]  in_data,
  input  logic [L_SHIFT-1:0]        in_shift,
  input  logic                      in_round,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CH*L_dataout-1:0] out_data,
  output logic [N_CH-1:0]           out_sat,
  output logic [L_CNT-1:0]          sat_cnt,
  input  logic                      sat_cnt_clr
);

  localparam int LW = L_datain + 1;

  logic                          s1_vld_q, s1_vld_d;
  logic [N_CH-1:0][LW-1:0]       s1_dat_q, s1_dat_d;
  logic                          out_vld_q, out_vld_d;
  logic [N_CH*L_dataout-1:0]     out_dat_q, out_dat_d;
  logic [N_CH-1:0]               out_sat_q, out_sat_d;

  logic [N_CH-1:0][LW-1:0]       lane_shifted;
  logic [N_CH*L_dataout-1:0]     lane_val;
  logic [N_CH-1:0]               lane_sat;
  logic                          s2_adv, s1_adv, in_hs;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    requant_lane #(
      .L_datain (L_datain),
      .L_dataout(L_dataout),
      .L_SHIFT  (L_SHIFT)
    ) u_lane (
      .din    (in_data[i*L_datain +: L_datain]),
      .shift  (in_shift),
      .round  (in_round),
      .shifted(lane_shifted[i]),
      .sat_in (s1_dat_q[i]),
      .res_val(lane_val[i*L_dataout +: L_dataout]),
      .res_sat(lane_sat[i])
    );
  end

  always_comb begin
    s2_adv    = !out_vld_q || out_ready;
    s1_adv    = !s1_vld_q || s2_adv;
    in_hs     = in_valid && s1_adv;
    s1_vld_d  = s1_vld_q;
    s1_dat_d  = s1_dat_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_sat_d = out_sat_q;
    if (s1_adv) begin
      s1_vld_d = in_valid;
    end
    if (in_hs) begin
      s1_dat_d = lane_shifted;
    end
    // Output regs only move on advance, which keeps them frozen under backpressure.
    if (s2_adv) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_dat_d = lane_val;
        out_sat_d = lane_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_sat_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign out_sat   = out_sat_q;

`ifdef SAT_STATS_EN
  logic [L_CNT-1:0] sat_cnt_q, sat_cnt_d;
  logic [L_CNT:0]   sat_pop;
  logic [L_CNT:0]   cnt_sum;
  logic             out_hs;

  // Clear has priority over a coincident handshake; the count saturates rather than wraps.
  always_comb begin
    out_hs  = out_vld_q && out_ready;
    sat_pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      sat_pop = sat_pop + (L_CNT + 1)'(out_sat_q[i]);
    end
    cnt_sum   = {1'b0, sat_cnt_q} + sat_pop;
    sat_cnt_d = sat_cnt_q;
    if (sat_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (out_hs) begin
      sat_cnt_d = cnt_sum[L_CNT] ? '1 : cnt_sum[L_CNT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat_cnt_clr;
  assign unused_sat_cnt_clr = sat_cnt_clr;
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_saturate_requant_pipe.sv
// Bench for saturate_requant_pipe: vector table, handshake corner sequences, random scoreboard run.
module tb_saturate_requant_pipe;
  import requant_pkg::*;

`ifdef SAT_STATS_EN
  localparam int  LC    = 4;
  localparam bit  STATS = 1'b1;
`else
  localparam int  LC    = 16;
  localparam bit  STATS = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [95:0]   in_data;
  logic [4:0]    in_shift;
  logic          in_round;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [3:0]    out_sat;
  logic [LC-1:0] sat_cnt;
  logic          sat_cnt_clr;

  saturate_requant_pipe #(.L_CNT(LC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shift   (in_shift),
    .in_round   (in_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_cnt    (sat_cnt),
    .sat_cnt_clr(sat_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  s;
  } exp_t;

  typedef struct {
    logic [95:0] din;
    logic [4:0]  sh;
    logic        rnd;
    logic [63:0] d;
    logic [3:0]  s;
  } vec_t;

  vec_t   tbl[6];
  exp_t   sb[$];
  exp_t   cur_exp;
  int     errors = 0;
  int     checks = 0;
  int     n_rx = 0;
  bit     last_in_hs, last_ov, last_in_rdy, held_vld;
  logic [67:0] held;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lane_res_t ref_lane(input logic [23:0] din, input logic [4:0] sh_in, input logic rnd);
    longint v, d, q;
    int sh;
    lane_res_t r;
    sh = (sh_in > 5'd23) ? 23 : int'(sh_in);
    v  = longint'($signed(din));
    d  = longint'(1) << sh;
    if (rnd && sh > 0) v = v + d / 2;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    if (q > 32767) begin
      r.val = 16'h7FFF; r.sat = 1'b1;
    end else if (q < -32768) begin
      r.val = 16'h8000; r.sat = 1'b1;
    end else begin
      r.val = 16'(q); r.sat = 1'b0;
    end
    return r;
  endfunction

  function automatic exp_t model_beat(input logic [95:0] din, input logic [4:0] sh, input logic rnd);
    exp_t e;
    lane_res_t r;
    e = '0;
    for (int l = 0; l < 4; l++) begin
      r = ref_lane(din[l*24 +: 24], sh, rnd);
      e.d[l*16 +: 16] = r.val;
      e.s[l] = r.sat;
    end
    return e;
  endfunction

  // One clock: sample handshakes at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_ov     = out_valid;
    last_in_rdy = in_ready;
    last_in_hs  = in_valid && in_ready && rst_n;
    if (held_vld) chk("hold_stable", {out_sat, out_data}, held);
    held_vld = out_valid && !out_ready && rst_n;
    held     = {out_sat, out_data};
    if (out_valid && out_ready && rst_n) begin
      n_rx++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sat", out_sat, e.s);
      end
    end
    if (last_in_hs) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [95:0] din, input logic [4:0] sh, input logic rnd, input exp_t e);
    int n;
    in_valid = 1'b1;
    in_data  = din;
    in_shift = sh;
    in_round = rnd;
    cur_exp  = e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_in_hs && n < 50);
    if (!last_in_hs) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rx0, sent, cyc, n;
    bit   saw_stall, have;
    logic [95:0] din;
    logic [4:0]  sh;
    logic        rnd;
    logic [31:0] r;
    logic [23:0] lv;

    tbl[0] = '{{24'hFF7FFF, 24'hFF8000, 24'h008000, 24'h007FFF}, 5'd0, 1'b0,
               {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF}, 4'b1010};
    tbl[1] = '{{24'hFFFFE8, 24'h000018, 24'hFFFFD8, 24'h000028}, 5'd4, 1'b1,
               {16'hFFFF, 16'h0002, 16'hFFFE, 16'h0003}, 4'b0000};
    tbl[2] = '{{24'hFFFFE8, 24'h000018, 24'hFFFFD8, 24'h000028}, 5'd4, 1'b0,
               {16'hFFFE, 16'h0001, 16'hFFFD, 16'h0002}, 4'b0000};
    tbl[3] = '{{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000}, 5'd31, 1'b1,
               {16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF}, 4'b0000};
    tbl[4] = '{{24'hFFFF80, 24'h000080, 24'h800000, 24'h7FFFFF}, 5'd8, 1'b0,
               {16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF}, 4'b0000};
    tbl[5] = '{{24'hFFFF80, 24'h000080, 24'h800000, 24'h7FFFFF}, 5'd8, 1'b1,
               {16'h0000, 16'h0001, 16'h8000, 16'h7FFF}, 4'b0001};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_round = 1'b0;
    out_ready = 1'b1; sat_cnt_clr = 1'b0; held_vld = 1'b0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Latency: handshake cycle, one empty cycle, then out_valid.
    send_beat(tbl[0].din, tbl[0].sh, tbl[0].rnd, '{tbl[0].d, tbl[0].s});
    out_ready = 1'b1;
    tick();
    chk("latency_c1_valid", last_ov, 0);
    tick();
    chk("latency_c2_valid", last_ov, 1);
    drain(2);

    for (int i = 0; i < 6; i++) begin
      send_beat(tbl[i].din, tbl[i].sh, tbl[i].rnd, '{tbl[i].d, tbl[i].s});
    end
    drain(4);
    chk("tbl_drained", sb.size(), 0);

    // Backpressure: out_ready low in stream cycles 3..5.
    rx0 = n_rx; sent = 0; saw_stall = 1'b0; cyc = 0;
    while ((sent < 6 || cyc < 7) && cyc < 40) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      din       = {4{24'(sent * 1000 - 2500)}};
      sh        = 5'(sent % 3);
      rnd       = sent[0];
      in_data   = din; in_shift = sh; in_round = rnd;
      cur_exp   = model_beat(din, sh, rnd);
      tick();
      if (!last_in_rdy) saw_stall = 1'b1;
      if (last_in_hs) sent++;
      cyc++;
    end
    drain(5);
    chk("stall_in_ready_dropped", saw_stall, 1);
    chk("stream_beats_out", n_rx - rx0, 6);
    chk("stream_drained", sb.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send_beat(tbl[1].din, tbl[1].sh, tbl[1].rnd, '{tbl[1].d, tbl[1].s});
    send_beat(tbl[2].din, tbl[2].sh, tbl[2].rnd, '{tbl[2].d, tbl[2].s});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    rx0 = n_rx;
    drain(6);
    chk("midrst_no_stale", n_rx - rx0, 0);

    // Saturation counter.
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("cnt_after_clr", sat_cnt, 0);
    din = {4{24'h7FFFFF}};
    send_beat(din, 5'd0, 1'b0, '{{4{16'h7FFF}}, 4'b1111});
    drain(3);
    chk("cnt_one_beat", sat_cnt, STATS ? 4 : 0);
    for (int i = 0; i < 4; i++) send_beat(din, 5'd0, 1'b0, '{{4{16'h7FFF}}, 4'b1111});
    drain(3);
    chk("cnt_sticky", sat_cnt, STATS ? 15 : 0);
    out_ready = 1'b0;
    send_beat(din, 5'd0, 1'b0, '{{4{16'h7FFF}}, 4'b1111});
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("cnt_clr_beat_ready", out_valid, 1);
    out_ready   = 1'b1;
    sat_cnt_clr = 1'b1;
    tick();
    sat_cnt_clr = 1'b0;
    chk("cnt_clr_wins", sat_cnt, 0);
    drain(2);

    // Random traffic against the reference model.
    rx0 = n_rx; sent = 0; cyc = 0; have = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (!have) begin
        for (int l = 0; l < 4; l++) begin
          r = $urandom;
          case (r[1:0])
            2'd0:    lv = r[31:8];
            2'd1:    lv = {{8{r[23]}}, r[23:8]};
            2'd2:    lv = r[8] ? 24'h7FFFFF : 24'h800000;
            default: lv = {{12{r[20]}}, r[20:9]};
          endcase
          din[l*24 +: 24] = lv;
        end
        sh  = 5'($urandom_range(0, 31));
        rnd = 1'($urandom_range(0, 1));
        in_data = din; in_shift = sh; in_round = rnd;
        cur_exp = model_beat(din, sh, rnd);
        have = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_in_hs) begin
        have = 1'b0;
        sent++;
      end
      cyc++;
    end
    drain(10);
    chk("rand_all_sent", sent, 10000);
    chk("rand_beats_out", n_rx - rx0, 10000);
    chk("rand_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
